// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline definitions: multiply/divide state encoding, register-number width,
// and default EX-stage multiply/divide latencies.
package pipe_hazard_ctrl_pkg;

    localparam int unsigned REG_W           = 5;
    localparam int unsigned CNT_W           = 6;
    localparam int unsigned DEF_MULT_CYCLES = 5;
    localparam int unsigned DEF_DIV_CYCLES  = 32;

    typedef enum logic {
        StIdle   = 1'b0,
        StMdBusy = 1'b1
    } md_state_e;

    // An ID source operand conflicts with an EX destination; register 0 never does.
    function automatic logic src_conflict(input logic             use_src,
                                          input logic [REG_W-1:0] src,
                                          input logic [REG_W-1:0] dst);
        return use_src && (src == dst) && (dst != '0);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_md_latency_counter.sv
// Down-counter tracking the remaining cycles of a multiply/divide operation.
module md_latency_counter
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard control: load-use and multiply/divide stalls, branch flush, and the
// multiply/divide occupancy tracker.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_md_read,
    input  logic             id_branch_taken,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_md_start,
    input  logic             ex_md_is_div,
    output logic             pc_wr,
    output logic             if_id_wr,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             md_busy,
    output logic             md_done
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    md_state_e        state_q, state_d;
    logic             cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0] cnt_load_val;
    logic             load_use, md_hazard, stall;

    assign cnt_load_val = ex_md_is_div ? DIV_LOAD : MULT_LOAD;

    md_latency_counter u_md_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // A start request while busy is ignored: only the idle branch may load.
    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (ex_md_start) begin
                    state_d  = StMdBusy;
                    cnt_load = 1'b1;
                end
            end
            StMdBusy: begin
                if (cnt_zero) begin
                    state_d = StIdle;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    assign load_use  = ex_mem_read && (src_conflict(id_use_rs, id_rs, ex_rd) ||
                                       src_conflict(id_use_rt, id_rt, ex_rd));
    assign md_hazard = (state_q == StMdBusy) && id_md_read;
    assign stall     = load_use || md_hazard;

    // Enables are forced low while reset is held so no pipeline register moves.
    always_comb begin
        pc_wr       = 1'b0;
        if_id_wr    = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        if (!rst) begin
            pc_wr       = !stall;
            if_id_wr    = !stall;
            id_ex_flush = stall;
            if_id_flush = id_branch_taken && !stall;
        end
    end

    assign md_busy = (state_q == StMdBusy);
    assign md_done = md_busy && cnt_zero;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench: a cycle model pushes expected controls as stimulus is driven; they are
// popped and compared against the DUT on the falling edge.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_rd;
    logic       id_use_rs, id_use_rt, id_md_read, id_branch_taken;
    logic       ex_mem_read, ex_md_start, ex_md_is_div;
    logic       pc_wr, if_id_wr, if_id_flush, id_ex_flush, md_busy, md_done;

    typedef struct packed {
        logic pc_wr;
        logic if_id_wr;
        logic if_id_flush;
        logic id_ex_flush;
        logic md_busy;
        logic md_done;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    // Reference model: busy flag plus count of busy cycles still to come.
    bit m_busy = 1'b0;
    int m_left = 0;

    pipe_hazard_ctrl #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (32)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_use_rs       (id_use_rs),
        .id_use_rt       (id_use_rt),
        .id_md_read      (id_md_read),
        .id_branch_taken (id_branch_taken),
        .ex_rd           (ex_rd),
        .ex_mem_read     (ex_mem_read),
        .ex_md_start     (ex_md_start),
        .ex_md_is_div    (ex_md_is_div),
        .pc_wr           (pc_wr),
        .if_id_wr        (if_id_wr),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .md_busy         (md_busy),
        .md_done         (md_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        id_rs           = 5'd0;
        id_rt           = 5'd0;
        ex_rd           = 5'd0;
        id_use_rs       = 1'b0;
        id_use_rt       = 1'b0;
        id_md_read      = 1'b0;
        id_branch_taken = 1'b0;
        ex_mem_read     = 1'b0;
        ex_md_start     = 1'b0;
        ex_md_is_div    = 1'b0;
    endtask

    // One cycle: predict, push, compare at negedge, then advance model across posedge.
    task automatic step();
        exp_t e, got;
        bit   lu, mh, st;
        if (rst) begin
            m_busy = 1'b0;
            m_left = 0;
        end
        lu = ex_mem_read && (ex_rd != 5'd0) &&
             ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));
        mh = m_busy && id_md_read;
        st = lu || mh;
        if (rst) begin
            e = '0;
        end else begin
            e.pc_wr       = !st;
            e.if_id_wr    = !st;
            e.id_ex_flush = st;
            e.if_id_flush = id_branch_taken && !st;
            e.md_busy     = m_busy;
            e.md_done     = m_busy && (m_left == 1);
        end
        sb_q.push_back(e);
        @(negedge clk);
        if (sb_q.size() == 0) begin
            check("sb_underflow", 32'd0, 32'd1);
        end else begin
            got = sb_q.pop_front();
            check("pc_wr",       {31'd0, pc_wr},       {31'd0, got.pc_wr});
            check("if_id_wr",    {31'd0, if_id_wr},    {31'd0, got.if_id_wr});
            check("if_id_flush", {31'd0, if_id_flush}, {31'd0, got.if_id_flush});
            check("id_ex_flush", {31'd0, id_ex_flush}, {31'd0, got.id_ex_flush});
            check("md_busy",     {31'd0, md_busy},     {31'd0, got.md_busy});
            check("md_done",     {31'd0, md_done},     {31'd0, got.md_done});
        end
        @(posedge clk);
        if (!rst) begin
            if (m_busy) begin
                m_left--;
                if (m_left == 0) m_busy = 1'b0;
            end else if (ex_md_start) begin
                m_busy = 1'b1;
                m_left = ex_md_is_div ? 32 : 5;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic set_load_use(input logic [4:0] rd);
        ex_mem_read = 1'b1;
        ex_rd       = rd;
        id_use_rs   = 1'b1;
        id_rs       = rd;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        step();
        ex_md_start = 1'b1;
        step();
        idle_inputs();

        rst = 1'b0;
        step();

        // Load-use on rs, then release; r0 never stalls; unused operand never stalls.
        set_load_use(5'd8);
        step();
        idle_inputs();
        step();
        set_load_use(5'd0);
        step();
        idle_inputs();
        ex_mem_read = 1'b1;
        ex_rd       = 5'd12;
        id_use_rt   = 1'b1;
        id_rt       = 5'd12;
        step();
        id_use_rt = 1'b0;
        step();
        idle_inputs();

        // Multiply with a dependent reader waiting throughout.
        ex_md_start = 1'b1;
        step();
        idle_inputs();
        id_md_read = 1'b1;
        repeat (6) step();
        idle_inputs();

        // Branch held off by a load-use, then flushed once the stall clears.
        set_load_use(5'd3);
        id_branch_taken = 1'b1;
        step();
        ex_mem_read = 1'b0;
        step();
        idle_inputs();

        // Divide with a second start at busy cycle 10 and a combined hazard at cycle 15.
        ex_md_start  = 1'b1;
        ex_md_is_div = 1'b1;
        step();
        idle_inputs();
        for (int i = 1; i <= 34; i++) begin
            idle_inputs();
            if (i == 10) begin
                ex_md_start  = 1'b1;
                ex_md_is_div = 1'b0;
            end
            if (i == 15) begin
                set_load_use(5'd9);
                id_md_read = 1'b1;
            end
            if (i == 31 || i == 32 || i == 33) id_md_read = 1'b1;
            step();
        end
        idle_inputs();

        // Reset lands asynchronously in busy cycle 7 of a divide.
        ex_md_start  = 1'b1;
        ex_md_is_div = 1'b1;
        step();
        idle_inputs();
        repeat (6) step();
        id_md_read = 1'b1;
        rst        = 1'b1;
        step();
        rst = 1'b0;
        step();
        idle_inputs();
        step();

        // Normal multiply after the aborted divide.
        ex_md_start = 1'b1;
        step();
        idle_inputs();
        repeat (6) step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
